// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: operand source encodings and default widths.
// Imported by the operand selector and by anything decoding out_sel.
package ex_pkg;

  localparam int EX_WIDTH   = 32;
  localparam int EX_NUM_SRC = 4;

  typedef enum logic [1:0] {
    SRC_REG     = 2'd0,
    SRC_IMM     = 2'd1,
    SRC_FWD_MEM = 2'd2,
    SRC_FWD_WB  = 2'd3
  } src_e;

endpackage

// File: rtl/ex_skid_buffer.sv
// Two-entry valid/ready skid buffer: main register drives the outputs,
// skid entry absorbs the one item accepted while in_ready is registered high.
module ex_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e       state_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         vld_q;
  logic         rdy_q;
  logic         accept;

  assign accept    = in_valid & rdy_q;
  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_data  = main_q;

  // in_ready/out_valid are registered copies of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else if (flush) begin
      state_q <= S_EMPTY;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_q  <= in_data;
            state_q <= S_ONE;
            vld_q   <= 1'b1;
          end
        end
        S_ONE: begin
          if (accept && out_ready) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q  <= in_data;
            state_q <= S_FULL;
            rdy_q   <= 1'b0;
          end else if (out_ready) begin
            state_q <= S_EMPTY;
            vld_q   <= 1'b0;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            main_q  <= skid_q;
            state_q <= S_ONE;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_EMPTY;
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_operand_select.sv
// EX-stage N:1 operand selector feeding a registered, flow-controlled
// skid stage; out_sel travels alongside the operand it produced.
module ex_operand_select
  import ex_pkg::*;
#(
  parameter  int WIDTH   = EX_WIDTH,
  parameter  int NUM_SRC = EX_NUM_SRC,
  localparam int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel
);

  localparam int PW = WIDTH + SEL_W;

  logic [WIDTH-1:0] chosen;
  logic [PW-1:0]    pl_in;
  logic [PW-1:0]    pl_out;

  // Unmatched indices (sel >= NUM_SRC) fall through to zero
  always_comb begin
    chosen = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (SEL_W'(k) == sel) begin
        chosen = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign pl_in = {sel, chosen};

  ex_skid_buffer #(
    .W(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (pl_in),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pl_out)
  );

  assign out_sel  = pl_out[PW-1 -: SEL_W];
  assign out_data = pl_out[WIDTH-1:0];

endmodule
